// File: rtl/gf_pkg.sv
// GF(2^SYMB_WIDTH) arithmetic and code dimensions shared by the RS decoder blocks.
// Field polynomial x^8+x^4+x^3+x^2+1 (0x11D), primitive element alpha = 0x02.
// All functions are pure combinational helpers.
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 8;
  localparam logic [SYMB_WIDTH:0] GF_POLY = 9'h11D;

  // Shift-and-add multiply with reduction folded into each shift of 'a'
  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ GF_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // a^-1 = a^(2^W-2) = product of a^(2^k) for k=1..W-1; maps 0 to 0
  function automatic logic [SYMB_WIDTH-1:0] gf_inv(input logic [SYMB_WIDTH-1:0] a);
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sq;
    acc = SYMB_WIDTH'(1);
    sq  = a;
    for (int k = 1; k < SYMB_WIDTH; k++) begin
      sq  = gf_mult(sq, sq);
      acc = gf_mult(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_berlekamp.sv
// Berlekamp-Massey solver: 2*T_LEN syndromes in, error-locator polynomial Lambda(x) out.
// Latency accept->vld: 4*T_LEN+1 cycles, or 2 cycles for an all-zero syndrome set when bypassed.
// Backpressure: syndrome_rdy only in IDLE; syndrome_vld elsewhere is ignored, output is a 1-cycle pulse.
module rs_berlekamp
  import gf_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [SYMB_WIDTH-1:0] syndrome [2*T_LEN-1:0],
  input  logic                  syndrome_vld,
  output logic                  syndrome_rdy,
  output logic [SYMB_WIDTH-1:0] error_locator [T_LEN:0],
  output logic                  error_locator_vld,
  output logic [$clog2(T_LEN+1):0] error_locator_deg,
  output logic                  decode_fail
);

  localparam int SW = SYMB_WIDTH;
  localparam int NS = 2 * T_LEN;
  localparam int RW = $clog2(NS);
  localparam int MW = $clog2(4 * T_LEN + 2);
  localparam int DW = $clog2(T_LEN + 1) + 1;
  localparam int CW = $clog2(T_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DISC, ST_UPDATE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q   [NS-1:0];
  logic [SW-1:0] s_d   [NS-1:0];
  logic [SW-1:0] c_q   [T_LEN:0];
  logic [SW-1:0] c_d   [T_LEN:0];
  logic [SW-1:0] bb_q  [T_LEN:0];
  logic [SW-1:0] bb_d  [T_LEN:0];
  logic [SW-1:0] el_q  [T_LEN:0];
  logic [SW-1:0] el_d  [T_LEN:0];
  logic [SW-1:0] bprev_q, bprev_d;
  logic [SW-1:0] delta_q, delta_d;
  logic [DW-1:0] l_q, l_d;
  logic [MW-1:0] m_q, m_d;
  logic [RW-1:0] r_q, r_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] deg_q, deg_d;
  logic          vld_q, vld_d;
  logic          fail_q, fail_d;
  logic          rdy_q, rdy_d;

  logic [SW-1:0] mul_a [T_LEN:0];
  logic [SW-1:0] mul_b [T_LEN:0];
  logic [SW-1:0] prod  [T_LEN:0];
  logic [SW-1:0] coef;
  logic [SW-1:0] disc;
  logic          s_zero;
  logic          ovf_now;
  logic [DW-1:0] cdeg;

  assign syndrome_rdy      = rdy_q;
  assign error_locator     = el_q;
  assign error_locator_vld = vld_q;
  assign error_locator_deg = deg_q;
  assign decode_fail       = fail_q;

  // Shared multiplier bank operands: C[i]*S[r-i] in DISC, coef*(x^m * B)[j] in UPDATE
  always_comb begin
    for (int i = 0; i <= T_LEN; i++) begin
      mul_a[i] = '0;
      mul_b[i] = '0;
    end
    if (state_q == ST_DISC) begin
      for (int i = 1; i <= T_LEN; i++) begin
        if ((DW'(i) <= l_q) && (RW'(i) <= r_q)) begin
          mul_a[i] = c_q[i];
          mul_b[i] = s_q[r_q - RW'(i)];
        end
      end
    end else if (state_q == ST_UPDATE) begin
      for (int j = 0; j <= T_LEN; j++) begin
        if (MW'(j) >= m_q) begin
          mul_a[j] = coef;
          mul_b[j] = bb_q[CW'(MW'(j) - m_q)];
        end
      end
    end
  end

  // The multiplier bank itself plus the correction coefficient delta/b
  always_comb begin
    for (int i = 0; i <= T_LEN; i++) prod[i] = gf_mult(mul_a[i], mul_b[i]);
    coef = gf_mult(delta_q, gf_inv(bprev_q));
  end

  // Reductions: discrepancy, zero-syndrome detect, truncated-term detect, actual degree of C
  always_comb begin
    disc = s_q[r_q];
    for (int i = 1; i <= T_LEN; i++) disc = disc ^ prod[i];
    s_zero = 1'b1;
    for (int k = 0; k < NS; k++) if (s_q[k] != '0) s_zero = 1'b0;
    // coef is nonzero whenever used, so a dropped term is nonzero exactly when B[k] is
    ovf_now = 1'b0;
    for (int k = 0; k <= T_LEN; k++) begin
      if (((MW'(k) + m_q) > MW'(T_LEN)) && (bb_q[k] != '0)) ovf_now = 1'b1;
    end
    cdeg = '0;
    for (int i = 0; i <= T_LEN; i++) if (c_q[i] != '0) cdeg = DW'(i);
  end

  // Next-state and next-register computation for the BM state machine
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    bb_d    = bb_q;
    el_d    = el_q;
    bprev_d = bprev_q;
    delta_d = delta_q;
    l_d     = l_q;
    m_d     = m_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    deg_d   = deg_q;
    vld_d   = 1'b0;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (syndrome_vld) begin
          s_d = syndrome;
          for (int i = 0; i <= T_LEN; i++) begin
            c_d[i]  = '0;
            bb_d[i] = '0;
          end
          c_d[0]  = SW'(1);
          bb_d[0] = SW'(1);
          bprev_d = SW'(1);
          delta_d = '0;
          l_d     = '0;
          m_d     = MW'(1);
          r_d     = '0;
          ovf_d   = 1'b0;
          state_d = ST_DISC;
        end
      end
      ST_DISC: begin
        delta_d = disc;
        // Zero detect works on the captured syndromes, keeping the input path shallow
        if (ZERO_BYPASS && s_zero) state_d = ST_DONE;
        else                       state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (delta_q == '0) begin
          m_d = m_q + MW'(1);
        end else begin
          for (int j = 0; j <= T_LEN; j++) c_d[j] = c_q[j] ^ prod[j];
          ovf_d = ovf_q | ovf_now;
          if ((DW + 1)'({l_q, 1'b0}) <= (DW + 1)'(r_q)) begin
            bb_d    = c_q;
            l_d     = DW'(r_q) + DW'(1) - l_q;
            bprev_d = delta_q;
            m_d     = MW'(1);
          end else begin
            m_d = m_q + MW'(1);
          end
        end
        if (r_q == RW'(NS - 1)) begin
          state_d = ST_DONE;
        end else begin
          r_d     = r_q + RW'(1);
          state_d = ST_DISC;
        end
      end
      ST_DONE: begin
        el_d    = c_q;
        deg_d   = l_q;
        vld_d   = 1'b1;
        fail_d  = (l_q > DW'(T_LEN)) | ovf_q | (cdeg != l_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // All state and registered outputs; reset forces IDLE with cleared outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NS; k++) s_q[k] <= '0;
      for (int i = 0; i <= T_LEN; i++) begin
        c_q[i]  <= '0;
        bb_q[i] <= '0;
        el_q[i] <= '0;
      end
      bprev_q <= '0;
      delta_q <= '0;
      l_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      deg_q   <= '0;
      vld_q   <= 1'b0;
      fail_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      bb_q    <= bb_d;
      el_q    <= el_d;
      bprev_q <= bprev_d;
      delta_q <= delta_d;
      l_q     <= l_d;
      m_q     <= m_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      deg_q   <= deg_d;
      vld_q   <= vld_d;
      fail_q  <= fail_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_rs_berlekamp.sv
// Directed bench for rs_berlekamp with GF(2^8)/0x11D, T_LEN=8.
// Two instances: ZERO_BYPASS=1 (main) and ZERO_BYPASS=0 (latency of the unbypassed path).
// Expected polynomials are hand-derived constants; syndromes are built from error lists.
module tb_rs_berlekamp;

  logic       aclk;
  logic       aresetn;
  logic [7:0] syndrome [15:0];
  logic       syndrome_vld;

  logic       rdy0, vld0, fail0;
  logic [7:0] el0 [8:0];
  logic [4:0] deg0;
  logic       rdy1, vld1, fail1;
  logic [7:0] el1 [8:0];
  logic [4:0] deg1;

  int n_vec = 0;
  int n_err = 0;

  int          lat0, lat1, pulses, rdy_bad;
  logic [71:0] lam0, lam1;
  logic [4:0]  dg0, dg1;
  logic        fl0, fl1;

  logic [7:0]  s_zero [15:0];
  logic [7:0]  s_one  [15:0];
  logic [7:0]  s_two  [15:0];
  logic [7:0]  s_nine [15:0];
  int          pos9 [9];
  logic [7:0]  val9 [9];
  int          roots;

  rs_berlekamp #(.ZERO_BYPASS(1'b1)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .syndrome(syndrome), .syndrome_vld(syndrome_vld), .syndrome_rdy(rdy0),
    .error_locator(el0), .error_locator_vld(vld0),
    .error_locator_deg(deg0), .decode_fail(fail0)
  );

  rs_berlekamp #(.ZERO_BYPASS(1'b0)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .syndrome(syndrome), .syndrome_vld(syndrome_vld), .syndrome_rdy(rdy1),
    .error_locator(el1), .error_locator_vld(vld1),
    .error_locator_deg(deg1), .decode_fail(fail1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Polynomial multiply then reduce, deliberately unlike the RTL's shift-reduce loop
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] tpow(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = tmul(r, a);
    return r;
  endfunction

  function automatic logic [71:0] pack(input logic [7:0] e [8:0]);
    logic [71:0] p;
    for (int i = 0; i <= 8; i++) p[i*8 +: 8] = e[i];
    return p;
  endfunction

  function automatic logic [7:0] lam_eval(input logic [71:0] lam, input logic [7:0] x);
    logic [7:0] acc;
    acc = '0;
    for (int i = 8; i >= 0; i--) acc = tmul(acc, x) ^ lam[i*8 +: 8];
    return acc;
  endfunction

  function automatic int count_roots(input logic [71:0] lam);
    logic [7:0] x;
    int n;
    x = 8'h01;
    n = 0;
    for (int i = 0; i < 255; i++) begin
      if (lam_eval(lam, x) == 8'h00) n++;
      x = tmul(x, 8'h02);
    end
    return n;
  endfunction

  // S[k] = sum_j e_j * X_j^(k+1) with X_j = alpha^pos_j
  task automatic mk_syn(input int n, input int pos [9], input logic [7:0] val [9],
                        output logic [7:0] s [15:0]);
    for (int k = 0; k < 16; k++) begin
      s[k] = 8'h00;
      for (int j = 0; j < n; j++) s[k] = s[k] ^ tmul(val[j], tpow(tpow(8'h02, pos[j]), k + 1));
    end
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One decode: present syndromes, then watch 45 cycles recording latency, pulses and rdy
  task automatic run(input logic [7:0] syn [15:0], input bit hold);
    lat0 = -1; lat1 = -1; pulses = 0; rdy_bad = 0;
    @(negedge aclk);
    syndrome     = syn;
    syndrome_vld = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    if (!hold) syndrome_vld = 1'b0;
    for (int cnt = 1; cnt <= 45; cnt++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (vld0) begin
        pulses++;
        if (lat0 < 0) begin
          lat0 = cnt; lam0 = pack(el0); dg0 = deg0; fl0 = fail0;
        end
        syndrome_vld = 1'b0;
      end else if (lat0 < 0 && rdy0) begin
        rdy_bad++;
      end
      if (vld1 && lat1 < 0) begin
        lat1 = cnt; lam1 = pack(el1); dg1 = deg1; fl1 = fail1;
      end
    end
    syndrome_vld = 1'b0;
  endtask

  initial begin
    int pos2 [9];
    logic [7:0] val2 [9];
    aresetn      = 1'b0;
    syndrome_vld = 1'b0;
    for (int k = 0; k < 16; k++) begin
      syndrome[k] = 8'h00;
      s_zero[k]   = 8'h00;
      s_one[k]    = 8'h01;
    end
    pos2 = '{3, 10, 0, 0, 0, 0, 0, 0, 0};
    val2 = '{8'h05, 8'h3A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    mk_syn(2, pos2, val2, s_two);
    pos9 = '{0, 7, 20, 33, 50, 61, 99, 140, 200};
    val9 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    mk_syn(9, pos9, val9, s_nine);

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_rdy",  72'(rdy0), 72'd1);
    chk("rst_vld",  72'(vld0), 72'd0);
    chk("rst_lam",  pack(el0), 72'h0);
    chk("rst_deg",  72'(deg0), 72'd0);
    chk("rst_fail", 72'(fail0), 72'd0);

    // All-zero syndromes: bypassed and full-iteration instances agree, differ in latency
    run(s_zero, 1'b0);
    chk("zero_lat_bypass", 72'(lat0), 72'd2);
    chk("zero_lat_full",   72'(lat1), 72'd33);
    chk("zero_lam_bypass", lam0, 72'h01);
    chk("zero_deg_bypass", 72'(dg0), 72'd0);
    chk("zero_fail_bypass", 72'(fl0), 72'd0);
    chk("zero_lam_full",   lam1, 72'h01);
    chk("zero_deg_full",   72'(dg1), 72'd0);
    chk("zero_fail_full",  72'(fl1), 72'd0);
    chk("zero_pulses",     72'(pulses), 72'd1);

    // Single error 0x01 at alpha^0: Lambda = 1 + x
    run(s_one, 1'b0);
    chk("one_lat",  72'(lat0), 72'd33);
    chk("one_lam",  lam0, 72'h0101);
    chk("one_deg",  72'(dg0), 72'd1);
    chk("one_fail", 72'(fl0), 72'd0);

    // Two errors at alpha^3, alpha^10: Lambda = 1 + 0x7C x + 0x87 x^2; vld held high throughout
    run(s_two, 1'b1);
    chk("two_lam",     lam0, 72'h877C01);
    chk("two_deg",     72'(dg0), 72'd2);
    chk("two_fail",    72'(fl0), 72'd0);
    chk("two_pulses",  72'(pulses), 72'd1);
    chk("two_rdy_low", 72'(rdy_bad), 72'd0);
    chk("two_roots",   72'(count_roots(lam0)), 72'd2);
    chk("two_root_p3",  72'(lam_eval(lam0, tpow(8'h02, 252))), 72'd0);
    chk("two_root_p10", 72'(lam_eval(lam0, tpow(8'h02, 245))), 72'd0);

    // Nine errors: either flagged or Lambda does not split into deg distinct roots
    run(s_nine, 1'b0);
    roots = count_roots(lam0);
    chk("nine_lat", 72'(lat0), 72'd33);
    chk("nine_detect", 72'(fl0 || (roots != int'(dg0))), 72'd1);

    // Reset during DISC of iteration 5: outputs clear at once, no pulse afterwards
    @(negedge aclk);
    syndrome     = s_two;
    syndrome_vld = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    syndrome_vld = 1'b0;
    repeat (9) @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("mid_rst_vld",  72'(vld0), 72'd0);
    chk("mid_rst_lam",  pack(el0), 72'h0);
    chk("mid_rst_deg",  72'(deg0), 72'd0);
    chk("mid_rst_fail", 72'(fail0), 72'd0);
    chk("mid_rst_rdy",  72'(rdy0), 72'd1);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (vld0) pulses++;
    end
    chk("mid_rst_no_pulse", 72'(pulses), 72'd0);

    // Fresh decode after the aborted one
    run(s_two, 1'b0);
    chk("post_rst_lat",  72'(lat0), 72'd33);
    chk("post_rst_lam",  lam0, 72'h877C01);
    chk("post_rst_deg",  72'(dg0), 72'd2);
    chk("post_rst_fail", 72'(fl0), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
